// File: rtl/led_period_meter.sv
// Half-period meter for a slow asynchronous toggling line (e.g. an LED drive).
// Synchronizes sig_in, detects both edges, and reports the cycle count between them.
//
// state      | meaning
// ST_IDLE    | no reference edge yet; cnt held at 0
// ST_MEASURE | counting clk cycles since the last detected edge
// ST_TIMEOUT | MAX_COUNT cycles passed without an edge; cnt saturated
module led_period_meter #(
  parameter int unsigned MAX_COUNT = 100000,
  parameter int          WIDTH     = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sig_in,
  output logic             level,
  output logic [WIDTH-1:0] period,
  output logic             period_valid,
  output logic             timeout
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_MEASURE = 2'd1,
    ST_TIMEOUT = 2'd2
  } state_t;

  localparam logic [WIDTH-1:0] CNT_LIMIT = WIDTH'(MAX_COUNT);

  logic             s1_q, s1_d;
  logic             s2_q, s2_d;
  logic             s3_q, s3_d;
  logic             edge_q, edge_d;
  state_t           state_q, state_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] cnt_inc;
  logic [WIDTH-1:0] period_q, period_d;
  logic             period_valid_q, period_valid_d;
  logic             timeout_q, timeout_d;

  // Edge is registered once more so the FSM acts on it three edges after
  // sig_in is first sampled; every edge sees the same delay, so periods are exact.
  always_comb begin
    s1_d   = sig_in;
    s2_d   = s1_q;
    s3_d   = s2_q;
    edge_d = s2_q ^ s3_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q   <= 1'b0;
      s2_q   <= 1'b0;
      s3_q   <= 1'b0;
      edge_q <= 1'b0;
    end else begin
      s1_q   <= s1_d;
      s2_q   <= s2_d;
      s3_q   <= s3_d;
      edge_q <= edge_d;
    end
  end

  assign cnt_inc = cnt_q + WIDTH'(1);

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    period_d       = period_q;
    period_valid_d = 1'b0;
    timeout_d      = timeout_q;
    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (edge_q) begin
          state_d = ST_MEASURE;
        end
      end
      ST_MEASURE: begin
        // An edge arriving on the terminal count still counts as a measurement.
        if (edge_q) begin
          period_d       = cnt_inc;
          period_valid_d = 1'b1;
          cnt_d          = '0;
        end else if (cnt_inc == CNT_LIMIT) begin
          state_d   = ST_TIMEOUT;
          timeout_d = 1'b1;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      ST_TIMEOUT: begin
        // Start of this interval is unknown, so no measurement is reported.
        if (edge_q) begin
          state_d   = ST_MEASURE;
          cnt_d     = '0;
          timeout_d = 1'b0;
        end
      end
      default: begin
        state_d   = ST_IDLE;
        cnt_d     = '0;
        timeout_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= ST_IDLE;
      cnt_q          <= '0;
      period_q       <= '0;
      period_valid_q <= 1'b0;
      timeout_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      period_q       <= period_d;
      period_valid_q <= period_valid_d;
      timeout_q      <= timeout_d;
    end
  end

  assign level        = s2_q;
  assign period       = period_q;
  assign period_valid = period_valid_q;
  assign timeout      = timeout_q;

endmodule

// File: tb/tb_led_period_meter.sv
// Directed bench for led_period_meter with MAX_COUNT=16, WIDTH=32.
// Windows start with a sig_in toggle just after a clock edge; a pulse lands on step 4.
module tb_led_period_meter;

  localparam int          WIDTH     = 32;
  localparam int unsigned MAX_COUNT = 16;

  logic             clk = 1'b0;
  logic             rst;
  logic             sig_in;
  logic             level;
  logic [WIDTH-1:0] period;
  logic             period_valid;
  logic             timeout;

  int checks   = 0;
  int failures = 0;

  int win_step, npulse, first_pulse, first_period;
  int tout_first, tout_low_first, tout_seen;
  int run_len, max_run, ones;

  led_period_meter #(.MAX_COUNT(MAX_COUNT), .WIDTH(WIDTH)) dut (
    .clk          (clk),
    .rst          (rst),
    .sig_in       (sig_in),
    .level        (level),
    .period       (period),
    .period_valid (period_valid),
    .timeout      (timeout)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic clear_win();
    win_step       = 0;
    npulse         = 0;
    first_pulse    = 0;
    first_period   = 0;
    tout_first     = 0;
    tout_low_first = 0;
    tout_seen      = 0;
    run_len        = 0;
    max_run        = 0;
    ones           = 0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    win_step++;
    if (period_valid) begin
      npulse++;
      if (first_pulse == 0) begin
        first_pulse  = win_step;
        first_period = int'(period);
      end
      run_len++;
      if (run_len > max_run) max_run = run_len;
      if (period == 1) ones++;
    end else begin
      run_len = 0;
    end
    if (timeout) begin
      tout_seen = 1;
      if (tout_first == 0) tout_first = win_step;
    end else if (tout_low_first == 0) begin
      tout_low_first = win_step;
    end
  endtask

  // Toggle sig_in, run n cycles, then check pulse count, latency, period and level.
  task automatic win(input string tag, input int n, input int exp_pulse, input int exp_period);
    clear_win();
    sig_in = ~sig_in;
    repeat (n) step();
    check({tag, "_pulses"}, npulse, exp_pulse);
    if (exp_pulse != 0) check({tag, "_latency"}, first_pulse, 4);
    check({tag, "_period"}, period, exp_period);
    check({tag, "_level"}, level, sig_in);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst    = 1'b1;
    sig_in = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_level", level, 0);
    check("rst_period", period, 0);
    check("rst_valid", period_valid, 0);
    check("rst_timeout", timeout, 0);

    rst = 1'b0;
    clear_win();
    repeat (10) step();
    check("idle_pulses", npulse, 0);
    check("idle_timeout", tout_seen, 0);
    check("idle_period", period, 0);

    for (int i = 1; i <= 6; i++) begin
      win($sformatf("tog5_%0d", i), 5, (i == 1) ? 0 : 1, (i == 1) ? 0 : 5);
    end

    clear_win();
    repeat (20) step();
    check("hold_timeout_step", tout_first, 15);
    check("hold_pulses", npulse, 0);
    check("hold_period", period, 5);
    check("hold_timeout_level", timeout, 1);

    clear_win();
    sig_in = ~sig_in;
    repeat (7) step();
    check("after_to_pulses", npulse, 0);
    check("after_to_clear_step", tout_low_first, 4);
    check("after_to_timeout", timeout, 0);
    check("after_to_period", period, 5);
    win("after_to_next", 7, 1, 7);

    win("edge16_a", 16, 1, 7);
    check("edge16_a_tout", tout_seen, 0);
    win("edge16_b", 16, 1, 16);
    check("edge16_b_tout", tout_seen, 0);
    win("edge16_c", 16, 1, 16);
    check("edge16_c_tout", tout_seen, 0);

    win("tog4_a", 4, 1, 16);
    check("tog4_a_tout", tout_seen, 0);
    win("tog4_b", 4, 1, 4);
    clear_win();
    sig_in = ~sig_in;
    step();
    step();
    rst = 1'b1;
    #1;
    check("midrst_period", period, 0);
    check("midrst_valid", period_valid, 0);
    check("midrst_timeout", timeout, 0);
    check("midrst_level", level, 0);
    step();
    step();
    rst = 1'b0;
    win("postrst_first", 4, 0, 0);
    win("postrst_second", 4, 1, 4);

    clear_win();
    for (int i = 0; i < 8; i++) begin
      sig_in = ~sig_in;
      step();
    end
    repeat (6) step();
    check("fast_pulses", npulse, 8);
    check("fast_first_step", first_pulse, 4);
    check("fast_first_period", first_period, 4);
    check("fast_ones", ones, 7);
    check("fast_consecutive", max_run, 8);
    check("fast_period", period, 1);
    check("fast_level", level, sig_in);

    sig_in = 1'b1;
    rst    = 1'b1;
    step();
    step();
    rst = 1'b0;
    clear_win();
    repeat (8) step();
    check("rel_high_pulses", npulse, 0);
    check("rel_high_level", level, 1);
    check("rel_high_timeout", timeout, 0);
    check("rel_high_period", period, 0);
    win("rel_high_next", 6, 1, 8);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
